// File: rtl/display_pkg.sv
// Shared field widths, shadow-entry layout and poller FSM states for the
// display-field polling interface.
package display_pkg;

   localparam int NAME_W  = 40;
   localparam int VALUE_W = 32;
   localparam int NUM_W   = 6;

   typedef struct packed {
      logic               present;
      logic [NAME_W-1:0]  name;
      logic [VALUE_W-1:0] value;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_WRAP
   } state_t;

endpackage

// File: rtl/field_shadow_ram.sv
// Shadow copy of every display slot with per-slot change flags, one capture
// write port and one registered clear-on-read port.
module field_shadow_ram
   import display_pkg::*;
#(
   parameter int NUM_FIELDS = 44
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               wr_en,
   input  logic [NUM_W-1:0]   wr_addr,
   input  logic               wr_present,
   input  logic [NAME_W-1:0]  wr_name,
   input  logic [VALUE_W-1:0] wr_value,
   input  logic               rd_en,
   input  logic [NUM_W-1:0]   rd_addr,
   output logic               rd_valid,
   output logic               rd_present,
   output logic [NAME_W-1:0]  rd_name,
   output logic [VALUE_W-1:0] rd_value,
   output logic               rd_changed,
   output logic               changed_any
);

   entry_t                  mem [NUM_FIELDS];
   logic [NUM_FIELDS-1:0]   flags;
   logic [NUM_FIELDS-1:0]   flags_nxt;
   entry_t                  wr_entry;
   entry_t                  rd_entry;
   logic                    rd_flag;

   // An unpopulated slot is stored as all zeros so stale responder data never
   // shows up as a change.
   always_comb begin
      wr_entry = '0;
      if (wr_present) begin
         wr_entry.present = 1'b1;
         wr_entry.name    = wr_name;
         wr_entry.value   = wr_value;
      end
   end

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      rd_entry  = '0;
      rd_flag   = 1'b0;
      flags_nxt = flags;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (rd_addr == NUM_W'(i + 1)) begin
            rd_entry = mem[i];
            rd_flag  = flags[i];
         end
         if (rd_en && rd_addr == NUM_W'(i + 1))
            flags_nxt[i] = 1'b0;
         // A capture that sets the flag overrides a same-cycle clear.
         if (wr_en && wr_addr == NUM_W'(i + 1) && wr_entry != mem[i])
            flags_nxt[i] = 1'b1;
      end
   end

   // NOTE: the shadow array is reset along with the flags because a cleared
   // frame after reset is observable through the read port; that rules out a
   // RAM macro, which is acceptable at 44 entries.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_FIELDS; i++)
            mem[i] <= '0;
         flags       <= '0;
         changed_any <= 1'b0;
         rd_valid    <= 1'b0;
         rd_present  <= 1'b0;
         rd_name     <= '0;
         rd_value    <= '0;
         rd_changed  <= 1'b0;
      end else begin
         flags       <= flags_nxt;
         changed_any <= |flags;
         rd_valid    <= rd_en;
         if (rd_en) begin
            rd_present <= rd_entry.present;
            rd_name    <= rd_entry.name;
            rd_value   <= rd_entry.value;
            rd_changed <= rd_flag;
         end
         for (int i = 0; i < NUM_FIELDS; i++)
            if (wr_en && wr_addr == NUM_W'(i + 1))
               mem[i] <= wr_entry;
      end
   end

endmodule

// File: rtl/display_poller.sv
// Polling initiator: steps display_number through slots 1..NUM_FIELDS, holding
// each for SCAN_DIV cycles, and captures the responder tuple into the shadow.
module display_poller
   import display_pkg::*;
#(
   parameter int NUM_FIELDS = 44,
   parameter int SCAN_DIV   = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               scan_en,
   output logic [NUM_W-1:0]   display_number,
   input  logic               display_valid,
   input  logic [NAME_W-1:0]  display_name,
   input  logic [VALUE_W-1:0] display_value,
   input  logic               rd_en,
   input  logic [NUM_W-1:0]   rd_addr,
   output logic               rd_valid,
   output logic               rd_present,
   output logic [NAME_W-1:0]  rd_name,
   output logic [VALUE_W-1:0] rd_value,
   output logic               rd_changed,
   output logic               frame_done,
   output logic               changed_any
);

   state_t           state;
   logic [NUM_W-1:0] slot;
   logic [7:0]       cnt;
   logic             capture;

   // Responders register one cycle after display_number moves, so the last
   // cycle of a slot sees settled data.
   assign capture        = (state == ST_SCAN) && (cnt == 8'(SCAN_DIV - 1));
   assign display_number = slot;

   // NOTE: state registers use non-blocking assignments so every branch sees
   // the values from before this edge, independent of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         slot       <= '0;
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (scan_en) begin
                  state <= ST_SCAN;
                  slot  <= NUM_W'(1);
                  cnt   <= '0;
               end
            end
            ST_SCAN: begin
               if (capture) begin
                  cnt <= '0;
                  if (slot < NUM_W'(NUM_FIELDS)) begin
                     slot <= slot + NUM_W'(1);
                  end else begin
                     state      <= ST_WRAP;
                     slot       <= '0;
                     frame_done <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_WRAP: begin
               if (scan_en) begin
                  state <= ST_SCAN;
                  slot  <= NUM_W'(1);
                  cnt   <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   field_shadow_ram #(
      .NUM_FIELDS (NUM_FIELDS)
   ) u_shadow (
      .clk         (clk),
      .resetn      (resetn),
      .wr_en       (capture),
      .wr_addr     (slot),
      .wr_present  (display_valid),
      .wr_name     (display_name),
      .wr_value    (display_value),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid),
      .rd_present  (rd_present),
      .rd_name     (rd_name),
      .rd_value    (rd_value),
      .rd_changed  (rd_changed),
      .changed_any (changed_any)
   );

endmodule
